// File: rtl/riscv_dbg_pkg.sv
// -----------------------------------------------------------------------------
// riscv_dbg_pkg
// Shared definitions for the debug-ring DII endpoints: packetizer FSM states,
// flag-flit field positions and packet type encodings.
// Optional build macro: RISCV_DII_PACKETIZER_TIMESTAMP_EN adds the TS state.
// -----------------------------------------------------------------------------
package riscv_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DEST,
      SRC,
      FLAGS,
`ifdef RISCV_DII_PACKETIZER_TIMESTAMP_EN
      TS,
`endif
      PAYLOAD
   } pkt_state_e;

   // Flags flit field positions
   localparam int TYPE_MSB    = 15;
   localparam int TYPE_LSB    = 14;
   localparam int SUBTYPE_MSB = 13;
   localparam int SUBTYPE_LSB = 10;

   // Packet type encodings
   localparam logic [1:0] TYPE_REG   = 2'b00;
   localparam logic [1:0] TYPE_PLAIN = 2'b01;
   localparam logic [1:0] TYPE_EVENT = 2'b10;

endpackage

// File: rtl/riscv_dii_packetizer.sv
// -----------------------------------------------------------------------------
// riscv_dii_packetizer
// Transmit-side debug-ring endpoint. Accepts one event request and emits it as
// a multi-flit DII packet: DEST, SRC, FLAGS, [TS], then 0..MAX_WORDS payload
// flits, with dii_out_last on the final flit.
//
// Optional build macro: RISCV_DII_PACKETIZER_TIMESTAMP_EN
//   Adds a free-running XLEN-bit cycle counter, sampled at acceptance and sent
//   as a TS flit between FLAGS and the payload.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id              this module's ring address (sent as source flit)
//   evt_valid/ready event request handshake (ready only in IDLE)
//   evt_dest        destination ring address
//   evt_type        packet type, evt_subtype packet subtype
//   evt_len         payload flit count (clamped to MAX_WORDS)
//   evt_payload     payload words, word 0 in the low XLEN bits, sent first
//   dii_out_*       flit stream towards the ring router local input
//   err_len         one-cycle pulse when an accepted evt_len exceeded MAX_WORDS
// -----------------------------------------------------------------------------
module riscv_dii_packetizer
   import riscv_dbg_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int MAX_WORDS = 8,
   parameter int LENW      = $clog2(MAX_WORDS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [XLEN-1:0]           id,
   input  logic                      evt_valid,
   output logic                      evt_ready,
   input  logic [XLEN-1:0]           evt_dest,
   input  logic [1:0]                evt_type,
   input  logic [3:0]                evt_subtype,
   input  logic [LENW-1:0]           evt_len,
   input  logic [MAX_WORDS*XLEN-1:0] evt_payload,
   output logic [XLEN-1:0]           dii_out_data,
   output logic                      dii_out_last,
   output logic                      dii_out_valid,
   input  logic                      dii_out_ready,
   output logic                      err_len
);

   // Index width needed to address the payload array; the length field is one
   // value wider because it also has to encode MAX_WORDS itself.
   localparam int IDXW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [LENW-1:0] MAX_LEN = LENW'(MAX_WORDS);

   pkt_state_e state_q, state_d;
   logic [LENW-1:0] idx_q, idx_d;

   logic [XLEN-1:0]                 dest_q;
   logic [XLEN-1:0]                 src_q;
   logic [1:0]                      type_q;
   logic [3:0]                      subtype_q;
   logic [LENW-1:0]                 len_q;
   logic [MAX_WORDS-1:0][XLEN-1:0]  payload_q;

   logic            accept;
   logic            len_over;
   logic [LENW-1:0] len_clamped;

   assign accept      = (state_q == IDLE) && evt_valid;
   assign len_over    = (evt_len > MAX_LEN);
   assign len_clamped = len_over ? MAX_LEN : evt_len;
   assign err_len     = accept && len_over && !rst;

`ifdef RISCV_DII_PACKETIZER_TIMESTAMP_EN
   logic [XLEN-1:0] ts_cnt_q;
   logic [XLEN-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt_q <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + XLEN'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         ts_q <= ts_cnt_q;
      end
   end
`endif

   // Control state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Packet contents captured at acceptance; inputs are free to change after.
   always_ff @(posedge clk) begin
      if (accept) begin
         dest_q    <= evt_dest;
         src_q     <= id;
         type_q    <= evt_type;
         subtype_q <= evt_subtype;
         len_q     <= len_clamped;
         payload_q <= evt_payload;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      evt_ready     = 1'b0;
      dii_out_valid = 1'b1;
      dii_out_last  = 1'b0;
      dii_out_data  = '0;

      case (state_q)
         IDLE: begin
            evt_ready     = 1'b1;
            dii_out_valid = 1'b0;
            if (evt_valid) begin
               state_d = DEST;
            end
         end

         DEST: begin
            dii_out_data = dest_q;
            if (dii_out_ready) begin
               state_d = SRC;
            end
         end

         SRC: begin
            dii_out_data = src_q;
            if (dii_out_ready) begin
               state_d = FLAGS;
            end
         end

         FLAGS: begin
            dii_out_data[TYPE_MSB:TYPE_LSB]       = type_q;
            dii_out_data[SUBTYPE_MSB:SUBTYPE_LSB] = subtype_q;
`ifdef RISCV_DII_PACKETIZER_TIMESTAMP_EN
            if (dii_out_ready) begin
               state_d = TS;
            end
`else
            dii_out_last = (len_q == '0);
            if (dii_out_ready) begin
               state_d = (len_q == '0) ? IDLE : PAYLOAD;
            end
`endif
         end

`ifdef RISCV_DII_PACKETIZER_TIMESTAMP_EN
         TS: begin
            dii_out_data = ts_q;
            dii_out_last = (len_q == '0);
            if (dii_out_ready) begin
               state_d = (len_q == '0) ? IDLE : PAYLOAD;
            end
         end
`endif

         PAYLOAD: begin
            // idx_q never exceeds len_q-1 <= MAX_WORDS-1, so the low IDXW bits
            // address the array exactly.
            dii_out_data = payload_q[idx_q[IDXW-1:0]];
            dii_out_last = (idx_q == (len_q - LENW'(1)));
            if (dii_out_ready) begin
               if (dii_out_last) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d   = idx_q + LENW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

endmodule

// File: doc/riscv_dii_packetizer.md
Name: riscv_dii_packetizer

Overview:
- Transmit-side endpoint of the debug ring: turns a single event request into a multi-flit DII packet on a ring router's local input port.
- Drives local_in_data/last/valid and honours local_in_ready.
- Packet layout: destination flit, source flit, flags flit, optional timestamp flit, then 0..MAX_WORDS payload flits; last marks the final flit.
- One instance per debug module sits between that module's event logic and its ring router.

Parameters:
- XLEN, 64, flit width in bits.
- MAX_WORDS, 8, maximum payload flits per packet.
- LENW, $clog2(MAX_WORDS+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id  in  XLEN  this module's ring address; sent as the source flit
- evt_valid  in  1  event request valid
- evt_ready  out  1  event request accepted
- evt_dest  in  XLEN  destination ring address
- evt_type  in  2  packet type
- evt_subtype  in  4  packet subtype
- evt_len  in  LENW  payload flit count
- evt_payload  in  MAX_WORDS*XLEN  payload words; word 0 is sent first
- dii_out_data  out  XLEN  flit data
- dii_out_last  out  1  final flit of the packet
- dii_out_valid  out  1  flit valid
- dii_out_ready  in  1  downstream ready
- err_len  out  1  one-cycle pulse when evt_len exceeded MAX_WORDS

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: FSM in IDLE; evt_ready=1; dii_out_valid=0; dii_out_last=0; dii_out_data=0; err_len=0; payload index=0.
- A reset mid-packet returns to IDLE next cycle and drops valid, truncating the packet. The ring routers share rst, so no recovery is attempted.
- FSM states: IDLE, DEST, SRC, FLAGS, TS (feature only), PAYLOAD.
- IDLE:
  - evt_ready=1 in this state only.
  - On evt_valid&&evt_ready, register evt_dest, id, type, subtype, clamped length and all payload words, then go to DEST.
  - Inputs are don't-care after acceptance.
- Length clamp: if evt_len>MAX_WORDS, use MAX_WORDS and pulse err_len in the acceptance cycle.
- Latency: the DEST flit is valid the cycle after acceptance.
- Flit contents:
  - DEST: dii_out_data=dest.
  - SRC: dii_out_data=id captured at acceptance.
  - FLAGS: data[15:14]=type, data[13:10]=subtype, all other bits 0.
- Handshake:
  - A flit transfers on dii_out_valid&&dii_out_ready, which advances the state.
  - While ready is low, data, last and valid are held stable. Valid never drops mid-packet except on reset.
- Last flit:
  - dii_out_last=1 on FLAGS when length==0 (or on TS when the feature is on).
  - Otherwise dii_out_last=1 on payload index length-1.
- PAYLOAD:
  - Index increments on each transfer; data=payload[index].
  - After the last transfer go to IDLE and clear the index.
- Back-to-back packets: exactly one bubble cycle (IDLE with evt_ready=1, valid=0) between packets.
- Payload index uses LENW bits and never wraps beyond length-1.

Optional Feature:
- Macro: RISCV_DII_PACKETIZER_TIMESTAMP_EN.
- Defined:
  - A free-running XLEN-bit counter increments every cycle, resets to 0 and wraps to 0.
  - Its value is sampled at event acceptance and sent as a TS flit between FLAGS and PAYLOAD.
  - A zero-payload packet is 4 flits with last on TS.
- Undefined: no counter and no TS state; a zero-payload packet is 3 flits.

Decomposition:
- riscv_dbg_pkg carries:
  - the FSM state enum;
  - flag-field bit positions (TYPE_MSB=15, TYPE_LSB=14, SUBTYPE_MSB=13, SUBTYPE_LSB=10);
  - type encodings (REG=2'b00, PLAIN=2'b01, EVENT=2'b10).
- Single module; no sub-module needed. The timestamp counter stays inline under the macro.

Test Plan:
- Reset, then id=5, dest=3, type=EVENT, subtype=1, len=2, payload={0xA,0xB}, ready=1:
  - flits 3, 5, 0x8400, 0xA, 0xB on consecutive cycles starting the cycle after acceptance;
  - last only on 0xB;
  - evt_ready returns 1 the cycle after.
- len=0 (feature off): 3 flits; last on flags flit 0x0000 (type REG); no payload flits.
- len=2 with dii_out_ready toggling 1,0,0,1,0,1…: data/last/valid stable while ready=0; flit order unchanged; total transfers=5.
- len=12 with MAX_WORDS=8: err_len pulses once at acceptance; exactly 8 payload flits; last on payload[7].
- rst asserted during payload flit 1 of 4: next cycle valid=0, evt_ready=1; next event packet is correct from DEST.
- Feature on, event accepted when counter=100, len=1: flits dest, src, flags, 100, payload[0]; last on payload[0].
